// File: rtl/bexkat1Def.sv
// bexkat1Def -- shared definitions for the bexkat1 decode stage.
//
// Holds the instruction type codes, the bit positions of every decoded
// field inside the 64-bit instruction word, the decoded-field bundle and
// the decode-state enum. Imported by idecode and idecode_fields.
package bexkat1Def;

  // Instruction type codes carried in ir[31:28].
  localparam logic [3:0] T_INH    = 4'h0;
  localparam logic [3:0] T_PUSH   = 4'h1;
  localparam logic [3:0] T_POP    = 4'h2;
  localparam logic [3:0] T_CMP    = 4'h3;
  localparam logic [3:0] T_MOV    = 4'h4;
  localparam logic [3:0] T_FPU    = 4'h5;
  localparam logic [3:0] T_FP     = 4'h6;
  localparam logic [3:0] T_ALU    = 4'h7;
  localparam logic [3:0] T_INT    = 4'h8;
  localparam logic [3:0] T_LDI    = 4'h9;
  localparam logic [3:0] T_LOAD   = 4'ha;
  localparam logic [3:0] T_STORE  = 4'hb;
  localparam logic [3:0] T_BRANCH = 4'hc;
  localparam logic [3:0] T_JUMP   = 4'hd;

  // Field positions within the instruction word.
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 28;
  localparam int OP_MSB   = 27;
  localparam int OP_LSB   = 24;
  localparam int RA_MSB   = 23;
  localparam int RA_LSB   = 20;
  localparam int RB_MSB   = 19;
  localparam int RB_LSB   = 16;
  localparam int RC_MSB   = 15;
  localparam int RC_LSB   = 12;
  localparam int SIMM_MSB = 15;  // short immediate ir[15:1], ir[15] is its sign
  localparam int SIMM_LSB = 1;
  localparam int LONG_BIT = 0;
  localparam int EXT_MSB  = 63;  // extension word holds the long immediate
  localparam int EXT_LSB  = 32;

  // Everything decode extracts from one instruction word.
  typedef struct packed {
    logic [3:0]  typ;
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [31:0] imm;
    logic        is_long;
    logic        bubble;   // the whole word is zero
  } fields_t;

  typedef enum logic {
    S_RUN       = 1'b0,
    S_INTERLOCK = 1'b1
  } decode_state_t;

endpackage

// File: rtl/idecode_fields.sv
// idecode_fields -- purely combinational field extraction.
//
// Splits an instruction word into its register/type/op fields and forms
// the 32-bit immediate: the extension word for long instructions, else
// the sign-extended short immediate ir[15:1].
//
// Ports:
//   ir     in  64  instruction word ([31:0] first word, [63:32] extension)
//   fields out     decoded field bundle (bexkat1Def::fields_t)
module idecode_fields
  import bexkat1Def::*;
(
  input  logic [63:0] ir,
  output fields_t     fields
);

  always_comb begin
    fields.typ     = ir[TYPE_MSB:TYPE_LSB];
    fields.op      = ir[OP_MSB:OP_LSB];
    fields.ra      = ir[RA_MSB:RA_LSB];
    fields.rb      = ir[RB_MSB:RB_LSB];
    fields.rc      = ir[RC_MSB:RC_LSB];
    fields.is_long = ir[LONG_BIT];
    fields.imm     = ir[LONG_BIT] ? ir[EXT_MSB:EXT_LSB]
                                  : {{17{ir[SIMM_MSB]}}, ir[SIMM_MSB:SIMM_LSB]};
    fields.bubble  = (ir == 64'h0);
  end

endmodule

// File: rtl/idecode.sv
// idecode -- bexkat1 instruction decode stage.
//
// Registers the fetched instruction, its PC and its decoded fields with
// one cycle of latency. Downstream stalls freeze every register; a PC
// redirect (flush) turns the instruction being captured into a bubble.
//
// Optional feature, macro BEXKAT1_IDECODE_HAZARD_EN: load-use interlock.
// When the latched instruction is a valid load whose ra is read (as rb or
// rc) by the incoming instruction, decode inserts exactly one bubble and
// stalls fetch for that cycle. Without the macro stall_o = stall_i.
//
// Ports:
//   clk_i    in   1   clock, rising edge
//   rst_i    in   1   synchronous active-high reset
//   ir_i     in   64  instruction word from fetch (64'h0 = bubble)
//   pc_i     in   32  fetch PC
//   stall_i  in   1   execute not ready: hold all output registers
//   flush_i  in   1   PC redirect: discard the instruction being captured
//   stall_o  out  1   to fetch: hold ir_i/pc_i
//   ir_o     out  64  latched instruction
//   pc_o     out  32  latched PC
//   valid_o  out  1   latched outputs hold a real instruction
//   type_o, op_o, ra_o, rb_o, rc_o  out 4  registered fields
//   imm_o    out  32  registered immediate
//   long_o   out  1   registered ir[0]
//   rd_a_o, rd_b_o  out 4  combinational register-file read addresses
module idecode
  import bexkat1Def::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] ir_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [63:0] ir_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [3:0]  type_o,
  output logic [3:0]  op_o,
  output logic [3:0]  ra_o,
  output logic [3:0]  rb_o,
  output logic [3:0]  rc_o,
  output logic [31:0] imm_o,
  output logic        long_o,
  output logic [3:0]  rd_a_o,
  output logic [3:0]  rd_b_o
);

  fields_t f_in;     // fields of the incoming word
  fields_t f_q;      // registered fields
  logic    hazard;   // load-use conflict that must become a bubble now

  idecode_fields u_fields (
    .ir     (ir_i),
    .fields (f_in)
  );

  // Register-file reads start while the instruction is still in decode.
  assign rd_a_o = f_in.rb;
  assign rd_b_o = f_in.rc;

`ifdef BEXKAT1_IDECODE_HAZARD_EN
  decode_state_t state, state_next;

  // Only checked in S_RUN: after the one inserted bubble the dependent
  // instruction is let through, since the load has then left decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hazard     = 1'b0;
    state_next = state;
    if (state == S_RUN && valid_o && f_q.typ == T_LOAD && !f_in.bubble &&
        (f_q.ra == f_in.rb || f_q.ra == f_in.rc))
      hazard = 1'b1;
    if (flush_i)
      state_next = S_RUN;
    else if (hazard)
      state_next = S_INTERLOCK;
    else
      state_next = S_RUN;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= S_RUN;
    else if (!stall_i)
      state <= state_next;
  end
`else
  assign hazard = 1'b0;
`endif

  // A flush outranks a hazard; either way the stall only matters to fetch
  // when the held instruction is still wanted.
  assign stall_o = stall_i | (hazard & ~flush_i);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      ir_o    <= 64'h0;
      pc_o    <= 32'h0;
      valid_o <= 1'b0;
      f_q     <= '0;
    end else if (!stall_i) begin
      pc_o <= pc_i;
      if (flush_i || hazard) begin
        ir_o    <= 64'h0;
        valid_o <= 1'b0;
        f_q     <= '0;
      end else begin
        ir_o    <= ir_i;
        valid_o <= ~f_in.bubble;
        f_q     <= f_in;
      end
    end
  end

  assign type_o = f_q.typ;
  assign op_o   = f_q.op;
  assign ra_o   = f_q.ra;
  assign rb_o   = f_q.rb;
  assign rc_o   = f_q.rc;
  assign imm_o  = f_q.imm;
  assign long_o = f_q.is_long;

endmodule

// File: tb/tb_idecode.sv
// tb_idecode -- self-checking bench for idecode.
//
// A behavioural model keeps the latched instruction word, PC, valid flag
// and whether a bubble was just inserted; every expected field is derived
// from the latched word at compare time. A compare process checks all
// outputs at each falling edge; directed vectors add literal checks.
// Works with and without BEXKAT1_IDECODE_HAZARD_EN.
module tb_idecode;
  import bexkat1Def::*;

`ifdef BEXKAT1_IDECODE_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] ir_i = '0;
  logic [31:0] pc_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o, valid_o, long_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o, imm_o;
  logic [3:0]  type_o, op_o, ra_o, rb_o, rc_o, rd_a_o, rd_b_o;

  idecode dut (
    .clk_i(clk_i), .rst_i(rst_i), .ir_i(ir_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
    .ir_o(ir_o), .pc_o(pc_o), .valid_o(valid_o),
    .type_o(type_o), .op_o(op_o), .ra_o(ra_o), .rb_o(rb_o), .rc_o(rc_o),
    .imm_o(imm_o), .long_o(long_o), .rd_a_o(rd_a_o), .rd_b_o(rd_b_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_ir    = '0;
  logic [31:0] m_pc    = '0;
  bit          m_valid = 1'b0;
  bit          m_after_bubble = 1'b0;  // hazard bubble inserted last cycle

  function automatic bit load_use();
    return HAZ_EN && !m_after_bubble && m_valid && m_ir[31:28] == T_LOAD &&
           ir_i != 64'h0 &&
           (m_ir[23:20] == ir_i[19:16] || m_ir[23:20] == ir_i[15:12]);
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_ir = '0; m_pc = '0; m_valid = 0; m_after_bubble = 0;
    end else if (!stall_i) begin
      if (flush_i) begin
        m_ir = '0; m_valid = 0; m_after_bubble = 0;
      end else if (load_use()) begin
        m_ir = '0; m_valid = 0; m_after_bubble = 1;
      end else begin
        m_ir = ir_i; m_pc = pc_i; m_valid = (ir_i != 0); m_after_bubble = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      int          simm;
      logic [31:0] exp_imm;
      simm    = $signed(m_ir[15:1]);
      exp_imm = m_ir[0] ? m_ir[63:32] : 32'(simm);
      check("ir_o",    ir_o,    m_ir);
      check("valid_o", valid_o, m_valid);
      if (m_valid) check("pc_o", pc_o, m_pc);
      check("type_o",  type_o,  m_ir[31:28]);
      check("op_o",    op_o,    m_ir[27:24]);
      check("ra_o",    ra_o,    m_ir[23:20]);
      check("rb_o",    rb_o,    m_ir[19:16]);
      check("rc_o",    rc_o,    m_ir[15:12]);
      check("imm_o",   imm_o,   exp_imm);
      check("long_o",  long_o,  m_ir[0]);
      check("stall_o", stall_o, stall_i | (load_use() & !flush_i));
      check("rd_a_o",  rd_a_o,  ir_i[19:16]);
      check("rd_b_o",  rd_b_o,  ir_i[15:12]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic [63:0] ir, input logic [31:0] pc,
                        input bit st = 0, input bit fl = 0, input bit rs = 0);
    ir_i = ir; pc_i = pc; stall_i = st; flush_i = fl; rst_i = rs;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input logic [63:0] ir, input logic [31:0] pc,
                     input bit st = 0, input bit fl = 0, input bit rs = 0);
    set_in(ir, pc, st, fl, rs);
    tick();
  endtask

  localparam logic [63:0] I_SHORT = 64'h0000_0000_1234_5676;
  localparam logic [63:0] I_LONG  = 64'hDEAD_BEEF_2000_0001;
  localparam logic [63:0] I_NEG   = 64'h0000_0000_7100_8002;
  localparam logic [63:0] I_LOAD  = 64'h0000_0000_A030_0000;  // load, ra=3
  localparam logic [63:0] I_DEPB  = 64'h0000_0000_7013_0000;  // rb=3
  localparam logic [63:0] I_DEPC  = 64'h0000_0000_7001_3000;  // rc=3
  localparam logic [63:0] I_INDEP = 64'h0000_0000_7004_4000;  // rb=rc=4
  localparam logic [63:0] I_NEXT  = 64'h0000_0000_4000_0002;

  initial begin
    // Reset
    cyc(I_SHORT, 32'h55, 0, 0, 1);
    chk_en = 1'b1;
    cyc(I_LONG, 32'h66, 1, 0, 1);
    check("reset ir_o", ir_o, 64'h0);
    check("reset pc_o", pc_o, 32'h0);
    check("reset valid_o", valid_o, 1'b0);
    check("reset imm_o", imm_o, 32'h0);

    // Short op
    cyc(I_SHORT, 32'h100);
    check("short valid", valid_o, 1'b1);
    check("short fields", {type_o, op_o, ra_o, rb_o, rc_o}, 20'h12345);
    check("short long", long_o, 1'b0);
    check("short imm", imm_o, 32'h0000_2B3B);
    check("short pc", pc_o, 32'h100);

    // Long op and negative short immediate
    cyc(I_LONG, 32'h104);
    check("long long_o", long_o, 1'b1);
    check("long imm", imm_o, 32'hDEAD_BEEF);
    cyc(I_NEG, 32'h108);
    check("neg imm", imm_o, 32'hFFFF_C001);

    // Load-use on rb, then on rc; fetch repeats the held instruction
    cyc(I_LOAD, 32'h10C);
    set_in(I_DEPB, 32'h110);
    #1 check("ld-rb stall_o", stall_o, HAZ_EN);
    tick();
    check("ld-rb bubble valid", valid_o, !HAZ_EN);
    cyc(I_DEPB, 32'h110);
    check("ld-rb dep ir", ir_o, I_DEPB);
    check("ld-rb dep valid", valid_o, 1'b1);
    cyc(I_LOAD, 32'h114);
    cyc(I_DEPC, 32'h118);
    check("ld-rc bubble valid", valid_o, !HAZ_EN);
    cyc(I_DEPC, 32'h118);
    check("ld-rc dep ir", ir_o, I_DEPC);

    // Independent of the load: no stall
    cyc(I_LOAD, 32'h11C);
    set_in(I_INDEP, 32'h120);
    #1 check("indep stall_o", stall_o, 1'b0);
    tick();
    check("indep valid", valid_o, 1'b1);

    // Flush in the hazard cycle
    cyc(I_LOAD, 32'h124);
    set_in(I_DEPB, 32'h128, 0, 1);
    #1 check("flush stall_o", stall_o, 1'b0);
    tick();
    check("flush valid", valid_o, 1'b0);
    check("flush ir", ir_o, 64'h0);
    cyc(I_DEPB, 32'h300);
    check("after flush valid", valid_o, 1'b1);

    // Three stall cycles with changing ir_i (one with flush, ignored)
    cyc(I_SHORT, 32'h200);
    for (int i = 0; i < 3; i++) begin
      set_in(i == 0 ? I_LONG : (i == 1 ? I_NEG : I_DEPB), 32'h204 + 32'(i), 1, i == 1);
      #1 check("stall stall_o", stall_o, 1'b1);
      tick();
      check("stall frozen ir", ir_o, I_SHORT);
      check("stall frozen pc", pc_o, 32'h200);
    end
    cyc(I_NEXT, 32'h210);
    check("post-stall ir", ir_o, I_NEXT);
    check("post-stall pc", pc_o, 32'h210);

    // Reset while interlocked
    cyc(I_LOAD, 32'h400);
    cyc(I_DEPB, 32'h404);
    cyc(I_DEPB, 32'h404, 0, 0, 1);
    check("rst-lock ir", ir_o, 64'h0);
    check("rst-lock valid", valid_o, 1'b0);
    check("rst-lock fields", {type_o, op_o, ra_o, rb_o, rc_o, long_o}, 21'h0);
    set_in(I_DEPB, 32'h404);
    #1 check("rst-lock stall_o", stall_o, 1'b0);
    tick();
    check("rst-lock capture", ir_o, I_DEPB);

    // Bubble after a load never stalls
    cyc(I_LOAD, 32'h500);
    set_in(64'h0, 32'h504);
    #1 check("bubble stall_o", stall_o, 1'b0);
    tick();
    check("bubble valid", valid_o, 1'b0);
    cyc(I_SHORT, 32'h508);

    @(negedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idecode.md
IDECODE -- requirements
Module: idecode

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 ir_i  input  64  instruction word from fetch; [31:0] first word, [63:32] extension word; 64'h0 = bubble.
REQ-004 pc_i  input  32  fetch PC, delivered alongside ir_i.
REQ-005 stall_i  input  1  downstream (execute) not ready; hold every output register.
REQ-006 flush_i  input  1  PC redirect (same signal as fetch pc_set); discard the instruction being captured.
REQ-007 stall_o  output  1  to fetch stall_i; fetch holds ir_i/pc_i while high.
REQ-008 ir_o  output  64  latched instruction.  pc_o  output  32  latched PC.
REQ-009 valid_o  output  1  ir_o/pc_o and decoded fields hold a real instruction.
REQ-010 type_o 4, op_o 4, ra_o 4, rb_o 4, rc_o 4  outputs  registered fields ir[31:28], [27:24], [23:20], [19:16], [15:12].
REQ-011 imm_o  output  32  ir[63:32] when long_o is set, else sign-extended ir[15:1].
REQ-012 long_o  output  1  registered ir[0].
REQ-013 rd_a_o, rd_b_o  outputs  4  combinational register-file read addresses = ir_i[19:16], ir_i[15:12].

Function
REQ-014 States S_RUN and S_INTERLOCK; reset enters S_RUN.
REQ-015 Latency: one cycle from ir_i/pc_i to registered outputs.
REQ-016 S_RUN, stall_i=0, flush_i=0, no hazard: capture ir_i, pc_i and all decoded fields; valid_o <= (ir_i != 0).
REQ-017 stall_i=1 (either state): all output registers and state hold; stall_o=1; flush_i ignored while stall_i=1.
REQ-018 flush_i=1, stall_i=0: ir_o <= 0, valid_o <= 0, state <= S_RUN; flush takes priority over hazard.
REQ-019 Hazard: valid_o=1, type_o=T_LOAD, and ra_o equals ir_i[19:16] or ir_i[15:12] of a nonzero ir_i.
REQ-020 Hazard in S_RUN, no stall/flush: stall_o=1 combinationally; registers load the bubble (ir_o=0, valid_o=0); state <= S_INTERLOCK.
REQ-021 S_INTERLOCK, no stall/flush: capture ir_i normally as in REQ-016; state <= S_RUN; stall_o=0; exactly one bubble per hazard.
REQ-022 stall_o = stall_i OR (hazard in S_RUN AND NOT flush_i).
REQ-023 Immediate: imm_o[31:15] all copies of ir_i[15]; no other width conversion.
REQ-024 A bubble (ir_i=0) never raises a hazard and produces valid_o=0.

Reset
REQ-025 On rst_i=1 at a clock edge: state=S_RUN, ir_o=0, pc_o=0, valid_o=0, every field output and imm_o=0, long_o=0.
REQ-026 Reset mid-interlock or mid-stall discards held state; stall_o follows only stall_i in the first post-reset cycle.

Configuration
REQ-027 Macro BEXKAT1_IDECODE_HAZARD_EN defined: REQ-019..REQ-022 load-use interlock present.
REQ-028 Macro undefined: no S_INTERLOCK state, no hazard logic, stall_o = stall_i; all other behaviour unchanged.

Structure
REQ-029 Instruction type codes (T_LOAD and the others), field bit positions and the decode-state enum live in package bexkat1Def.
REQ-030 One sub-module, idecode_fields: purely combinational field extraction and immediate formation, shared by the capture path and the hazard compare.

Verification
REQ-031 Short op: ir_i=64'h0000_0000_1234_5676, pc_i=32'h100 -> next cycle valid_o=1, type_o=1, op_o=2, ra_o=3, rb_o=4, rc_o=5, long_o=0, imm_o=32'h0000_2B3B, pc_o=32'h100.
REQ-032 Long op: ir_i=64'hDEAD_BEEF_2000_0001 -> long_o=1, imm_o=32'hDEAD_BEEF; negative short imm ir[15]=1 -> imm_o[31:15] all ones.
REQ-033 Load-use (HAZARD_EN): latched T_LOAD with ra=3, then ir_i with rb=3 -> stall_o=1 for one cycle, one valid_o=0 bubble, dependent instruction appears the following cycle; rc=3 behaves the same; rb=rc=4 -> no stall.
REQ-034 Flush during hazard: flush_i=1 in the hazard cycle -> stall_o=0, valid_o=0 next cycle, state S_RUN.
REQ-035 stall_i=1 for 3 cycles with changing ir_i -> outputs frozen and stall_o=1 throughout, then the next instruction is captured when stall_i drops.
REQ-036 Reset asserted in S_INTERLOCK -> all outputs 0 the next cycle; build without the macro -> REQ-033 stimulus yields stall_o=0 and no bubble.
